// File: rtl/rng_sampler_pkg.sv
// Shared types and helpers for the random-range sampler: FSM states, word width
// and the multiply-high scaling function.
package rng_sampler_pkg;

    localparam int RAND_W  = 32;
    localparam int SCALE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Upper bits of word*range are floor(word*range/2^32), hence always < range.
    function automatic logic [SCALE_W-1:0] scale_word(
        input logic [RAND_W-1:0]  word,
        input logic [SCALE_W-1:0] range
    );
        logic [RAND_W+SCALE_W-1:0] product;
        product = {{SCALE_W{1'b0}}, word} * {{RAND_W{1'b0}}, range};
        return product[RAND_W+SCALE_W-1:RAND_W];
    endfunction

endpackage

// File: rtl/rng_sampler_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head is presented whenever
// non-empty and reads as zero when empty.
module rng_sampler_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_do_pop  = pop && (r_count != {CW{1'b0}});
    assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointer width makes wrap modulo DEPTH implicit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = (r_count != {CW{1'b0}}) ? r_mem[r_rd_ptr] : {WIDTH{1'b0}};
    assign count   = r_count;

endmodule

// File: rtl/rng_range_sampler.sv
// Random-word consumer: starts the generator, scales each word into [0, range_n)
// and prefetches indices. Optional counters under RNG_SAMPLER_STATS_EN.
module rng_range_sampler
    import rng_sampler_pkg::*;
#(
    parameter int RANGE_W = 8,
    parameter int DEPTH   = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               enable,
    input  logic [RANGE_W-1:0] range_n,
    output logic               rng_start,
    input  logic [RAND_W-1:0]  rand_num_data,
    input  logic               rand_num_valid,
    output logic               rand_num_ready,
    output logic [RANGE_W-1:0] sample_data,
    output logic               sample_valid,
`ifdef RNG_SAMPLER_STATS_EN
    output logic [31:0]        stat_words,
    output logic [31:0]        stat_starve,
`endif
    input  logic               sample_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_pipe_valid;
    logic [RANGE_W-1:0] r_pipe_data;
    logic [CW-1:0]      w_fifo_count;
    logic [CW-1:0]      w_occupancy;
    logic               w_accept;

    // Control state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: START lasts exactly one cycle regardless of enable.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = START;
                else        w_state_nxt = IDLE;
            end
            START: w_state_nxt = RUN;
            RUN: begin
                if (!enable) w_state_nxt = IDLE;
                else         w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // In-flight pipe word counts against capacity so a push can never overflow.
    assign w_occupancy    = w_fifo_count + CW'(r_pipe_valid);
    assign rng_start      = (r_state == START);
    assign rand_num_ready = (r_state == RUN) && enable && (w_occupancy < CW'(DEPTH));
    assign w_accept       = rand_num_valid && rand_num_ready;

    // Scaling stage: range_n is captured with the word it applies to.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= {RANGE_W{1'b0}};
        end else begin
            r_pipe_valid <= w_accept;
            if (w_accept) begin
                r_pipe_data <= RANGE_W'(scale_word(rand_num_data, SCALE_W'(range_n)));
            end else begin
                r_pipe_data <= r_pipe_data;
            end
        end
    end

    rng_sampler_fifo #(
        .WIDTH (RANGE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (r_pipe_valid),
        .push_data (r_pipe_data),
        .pop       (sample_ready),
        .rd_data   (sample_data),
        .count     (w_fifo_count)
    );

    assign sample_valid = (w_fifo_count != {CW{1'b0}});

`ifdef RNG_SAMPLER_STATS_EN
    logic [31:0] r_stat_words;
    logic [31:0] r_stat_starve;

    // Free-running wrap-around event counters.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_stat_words  <= 32'd0;
            r_stat_starve <= 32'd0;
        end else begin
            if (w_accept) begin
                r_stat_words <= r_stat_words + 32'd1;
            end
            if (sample_ready && !sample_valid) begin
                r_stat_starve <= r_stat_starve + 32'd1;
            end
        end
    end

    assign stat_words  = r_stat_words;
    assign stat_starve = r_stat_starve;
`endif

endmodule
